// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer.
//   mem_state_e     : sequencer state encoding (IDLE/LO/HI/DONE)
//   MEM_BEAT_W      : external data bus width in bits
//   MEM_ERR_DATA    : load value substituted when a beat times out
//   MEM_TIMEOUT_DEF : default per-beat acknowledge timeout in cycles
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    localparam int          MEM_BEAT_W      = 16;
    localparam logic [31:0] MEM_ERR_DATA    = 32'hDEADBEEF;
    localparam int          MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Per-beat watchdog for the memory sequencer. Only compiled when
// MEM_CTRL_TIMEOUT_EN is defined.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : reload the counter (start of a new beat)
//   en_i      : count this cycle (beat active, no acknowledge)
//   expire_o  : high in the TIMEOUT_CYCLES-th consecutive enabled cycle
`ifdef MEM_CTRL_TIMEOUT_EN
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter: loaded with TIMEOUT_CYCLES-1 so the terminal count is
    // reached in the TIMEOUT_CYCLES-th waiting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = CNT_LOAD;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= CNT_LOAD;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Sequencer between the EXE/MEM pipeline register and a 16-bit data memory.
// Each 32-bit load/store becomes two half-word beats (low at base, high at
// base+2) over a req/ack handshake while freeze stalls the pipeline.
//
// Optional feature: MEM_CTRL_TIMEOUT_EN adds a per-beat ack watchdog that
// aborts the access, pulses bus_err and returns MEM_ERR_DATA on loads.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   mem_r_en, mem_w_en       : load / store request (store wins if both)
//   alu_result, st_val       : byte address, store data
//   freeze                   : pipeline stall
//   rdata                    : last completed load word
//   bus_err                  : one-cycle pulse on timeout abort
//   mem_req, mem_we          : bus request / write strobe
//   mem_addr, mem_wdata      : bus byte address / write half-word
//   mem_rdata, mem_ack       : bus read half-word / beat acknowledge
//
// state | meaning
// IDLE  | waiting for a request; latches address, data and direction
// LO    | low half-word beat at base
// HI    | high half-word beat at base+2
// DONE  | access finished, freeze released for one cycle
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           st_val,
    output logic                  freeze,
    output logic [31:0]           rdata,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_BEAT_W-1:0] mem_wdata,
    input  logic [MEM_BEAT_W-1:0] mem_rdata,
    input  logic                  mem_ack
);

    mem_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [MEM_BEAT_W-1:0] wdata_q;
    logic [MEM_BEAT_W-1:0] st_hi_q;
    logic [MEM_BEAT_W-1:0] rbuf_lo_q;
    logic [31:0]           rdata_q;
    logic                  wr_q;
    logic                  req_in;
    logic                  in_beat;
    logic                  expire;
    logic                  unused_bits;

    assign req_in  = mem_r_en | mem_w_en;
    assign in_beat = (state_q == ST_LO) || (state_q == ST_HI);

    // Byte-lane bits of the address are not used: accesses are word aligned.
    assign unused_bits = (^alu_result[1:0]) ^ (TIMEOUT_CYCLES > 0);

`ifdef MEM_CTRL_TIMEOUT_EN
    logic beat_start;
    logic bus_err_q;

    assign beat_start = ((state_q == ST_IDLE) && req_in) ||
                        ((state_q == ST_LO) && mem_ack);

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (beat_start),
        .en_i     (in_beat && !mem_ack),
        .expire_o (expire)
    );

    // Expiry forces DONE, so this is high for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_err_q <= 1'b0;
        else
            bus_err_q <= in_beat && expire;
    end

    assign bus_err = bus_err_q;
`else
    assign expire  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; an acknowledge takes priority over expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_in)  state_d = ST_LO;
            ST_LO: begin
                if (mem_ack)      state_d = ST_HI;
                else if (expire)  state_d = ST_DONE;
            end
            ST_HI: begin
                if (mem_ack || expire) state_d = ST_DONE;
            end
            default:              state_d = ST_IDLE;
        endcase
    end

    // Outputs: bus controls come from registered state only.
    always_comb begin
        mem_req = in_beat;
        mem_we  = in_beat && wr_q;
        freeze  = req_in && (state_q != ST_DONE);
    end

    // Address and write data are registered at beat entry so they hold
    // their last value through DONE/IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            st_hi_q   <= '0;
            rbuf_lo_q <= '0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_in) begin
                        addr_q  <= {alu_result[ADDR_W-1:2], 2'b00};
                        wdata_q <= st_val[15:0];
                        st_hi_q <= st_val[31:16];
                        wr_q    <= mem_w_en;
                    end
                end
                ST_LO: begin
                    if (mem_ack) begin
                        rbuf_lo_q <= mem_rdata;
                        addr_q    <= addr_q + ADDR_W'(2);
                        wdata_q   <= st_hi_q;
                    end else if (expire && !wr_q) begin
                        rdata_q <= MEM_ERR_DATA;
                    end
                end
                ST_HI: begin
                    if (mem_ack) begin
                        if (!wr_q)
                            rdata_q <= {mem_rdata, rbuf_lo_q};
                    end else if (expire && !wr_q) begin
                        rdata_q <= MEM_ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the EXE/MEM pipeline register and a 16-bit external data memory. It turns each 32-bit load or store held in that register into two 16-bit bus beats over a req/ack handshake. While the access is in flight it asserts `freeze` so every pipeline register holds its contents. Load data is delivered as one 32-bit word to the MEM/WB path.

## Interface
Parameters:
- `ADDR_W`, 32: width of the byte address driven on the memory bus.
- `TIMEOUT_CYCLES`, 255: maximum wait for `mem_ack` per beat. Used only with the timeout feature.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_en`  in  1  load request from the EXE/MEM register.
- `mem_w_en`  in  1  store request from the EXE/MEM register.
- `alu_result`  in  32  byte address of the access.
- `st_val`  in  32  store data.
- `freeze`  out  1  stall for all pipeline registers.
- `rdata`  out  32  last completed load word.
- `bus_err`  out  1  one-cycle pulse when an access is aborted on timeout.
- `mem_req`  out  1  bus request, held until acknowledged.
- `mem_we`  out  1  bus write strobe.
- `mem_addr`  out  ADDR_W  bus byte address.
- `mem_wdata`  out  16  bus write half-word.
- `mem_rdata`  in  16  bus read half-word, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle beat-complete acknowledge.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE, when `mem_r_en|mem_w_en`:
  - latch the address as `{alu_result[ADDR_W-1:2],2'b00}`; address bits [1:0] are ignored.
  - latch `st_val` and the write flag.
  - next state LO.
- If both enables are high, the access is a store and `rdata` is unchanged.
- LO: `mem_req=1`, `mem_addr=base`, `mem_wdata=st_val[15:0]`. On `mem_ack`, capture `mem_rdata` into the low half of the read buffer and go to HI.
- HI: `mem_req=1`, `mem_addr=base+2`, `mem_wdata=st_val[31:16]`. On `mem_ack`, go to DONE.
  - On a load, `rdata` updates at this same edge to `{mem_rdata, low half}`.
- DONE: `freeze=0`, so the pipeline advances at this edge. Next state is always IDLE.
- `freeze = (mem_r_en|mem_w_en) & (state != DONE)`. This is combinational, so the stall starts in the cycle the request first appears in IDLE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state and latched registers only. They do not depend combinationally on the pipeline inputs.
- In IDLE and DONE: `mem_req=0`, `mem_we=0`, address and write data hold their last values.
- `mem_ack` outside LO/HI is ignored.

## Timing
- Reset values: state IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `rdata=0`, `bus_err=0`. `freeze` follows its equation, so it is 1 if a request is present during reset.
- Reset mid-access:
  - `mem_req` drops asynchronously.
  - the in-flight beat is abandoned and `rdata` returns to 0.
- Latency with `mem_ack` in the first cycle of each beat is 4 cycles (IDLE, LO, HI, DONE), with `freeze` high for 3 of them. Each extra wait cycle on a beat adds one cycle.
- Back-to-back accesses: DONE always passes through IDLE. A request present in that IDLE cycle starts a new access with no extra gap.

## Configuration
- `MEM_CTRL_TIMEOUT_EN` defined:
  - a per-beat counter clears on entry to LO/HI and counts while `mem_ack=0`.
  - when it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE and `bus_err` pulses for one cycle.
  - a load that times out sets `rdata=32'hDEADBEEF`.
  - a store that times out is dropped.
- Undefined: the counter logic is absent, the FSM waits indefinitely, and `bus_err` is tied to 0.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum (IDLE/LO/HI/DONE).
  - `MEM_BEAT_W=16`.
  - `MEM_ERR_DATA=32'hDEADBEEF`.
  - default `TIMEOUT_CYCLES`.
- Sub-module `mem_timeout_cnt` holds the watchdog counter with clear, enable and expire outputs. It is instantiated only under `MEM_CTRL_TIMEOUT_EN`.

## Test plan
- Load from `alu_result=0x0000_0104`, bus returns 0xBEEF then 0xDEAD with immediate ack:
  - `mem_addr` 0x104 then 0x106.
  - `rdata=0xDEADBEEF` at the end of HI.
  - `freeze` high for exactly 3 cycles.
- Store of `st_val=0x1234_5678` to 0x200 with 2 wait cycles per beat:
  - beats 0x5678@0x200 and 0x1234@0x202 with `mem_we=1`.
  - `freeze` high for 7 cycles.
  - `rdata` unchanged.
- Back-to-back load then store: the second access starts in the IDLE cycle right after DONE, and `mem_req` drops only during the DONE and IDLE cycles.
- Assert `rst` during HI: `mem_req` drops the same cycle, state is IDLE, `rdata=0`, and a held request restarts at LO after reset release.
- `MEM_CTRL_TIMEOUT_EN` with `TIMEOUT_CYCLES=4` and no ack: a load completes with `rdata=0xDEADBEEF`, `bus_err` pulses once, and `freeze` releases.
- Both enables high with `alu_result=0x10`: a store is performed and `rdata` keeps its prior value.
